// File: rtl/hwpe_stream_burst_reader_if.sv
// HWPE-Stream handshake bundle: valid/ready plus data and byte strobes.
// The producer drives valid/data/strb through the source (master) view.
// The consumer drives ready through the sink (slave) view.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);
endinterface

// File: rtl/hwpe_stream_burst_reader.sv
// hwpe_stream_burst_reader: pops exactly len_i beats from an HWPE-Stream FIFO.
// Each beat is forwarded through a 2-entry registered skid buffer, with last_o on the final beat.
// done_o pulses one cycle after the final beat leaves out_o.
// Optional feature macro: HWPE_STREAM_BURST_READER_STRB_CHECK_EN adds a sticky strb_err_o flag.
// That flag marks a partial-strobe beat anywhere before the final beat.
module hwpe_stream_burst_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   last_o,
`ifdef HWPE_STREAM_BURST_READER_STRB_CHECK_EN
  output logic                   strb_err_o,
`endif
  hwpe_stream_intf_stream.sink   in_i,
  hwpe_stream_intf_stream.source out_o
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len_q;
  logic [LEN_WIDTH-1:0]  r_in_cnt;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [DATA_WIDTH-1:0] r_buf_data [0:1];
  logic [STRB_WIDTH-1:0] r_buf_strb [0:1];
  logic [1:0]            r_buf_cnt;
  logic                  r_done;

  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_out_valid;
  logic                  w_pop;
  logic [LEN_WIDTH-1:0]  w_len_m1;
  logic                  w_last;
  logic                  w_in_final;

  // Entry 0 of the buffer is always the head, so out_o is driven straight from registers.
  // Ready never looks at in_i.valid; it only needs a free slot while running.
  assign w_in_ready  = (r_state == RUN) && (r_buf_cnt < 2'd2);
  assign w_push      = in_i.valid && w_in_ready;
  assign w_out_valid = (r_buf_cnt != 2'd0);
  assign w_pop       = w_out_valid && out_o.ready;
  assign w_len_m1    = r_len_q - LEN_WIDTH'(1);
  assign w_last      = w_out_valid && (r_out_cnt == w_len_m1);
  assign w_in_final  = (r_in_cnt == w_len_m1);

  assign in_i.ready  = w_in_ready;
  assign out_o.valid = w_out_valid;
  assign out_o.data  = r_buf_data[0];
  assign out_o.strb  = r_buf_strb[0];
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign last_o      = w_last;

  // Burst FSM, beat counters, skid buffer and registered done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state       <= IDLE;
      r_len_q       <= {LEN_WIDTH{1'b0}};
      r_in_cnt      <= {LEN_WIDTH{1'b0}};
      r_out_cnt     <= {LEN_WIDTH{1'b0}};
      r_buf_data[0] <= {DATA_WIDTH{1'b0}};
      r_buf_data[1] <= {DATA_WIDTH{1'b0}};
      r_buf_strb[0] <= {STRB_WIDTH{1'b0}};
      r_buf_strb[1] <= {STRB_WIDTH{1'b0}};
      r_buf_cnt     <= 2'd0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_len_q   <= len_i;
            r_in_cnt  <= {LEN_WIDTH{1'b0}};
            r_out_cnt <= {LEN_WIDTH{1'b0}};
            if (len_i != {LEN_WIDTH{1'b0}}) begin
              r_state <= RUN;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_push && w_in_final) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Counters cannot move in IDLE: there is no push there and the buffer is empty.
      // In RUN/DRAIN these updates take priority over nothing else.
      if (w_push) begin
        r_in_cnt <= r_in_cnt + LEN_WIDTH'(1);
      end
      if (w_pop) begin
        r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) begin
            r_buf_data[0] <= in_i.data;
            r_buf_strb[0] <= in_i.strb;
          end else begin
            r_buf_data[1] <= in_i.data;
            r_buf_strb[1] <= in_i.strb;
          end
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_strb[0] <= r_buf_strb[1];
          r_buf_cnt     <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          // The count stays the same; the new beat goes in behind whatever remains.
          if (r_buf_cnt == 2'd1) begin
            r_buf_data[0] <= in_i.data;
            r_buf_strb[0] <= in_i.strb;
          end else begin
            r_buf_data[0] <= r_buf_data[1];
            r_buf_strb[0] <= r_buf_strb[1];
            r_buf_data[1] <= in_i.data;
            r_buf_strb[1] <= in_i.strb;
          end
        end
        default: begin
          r_buf_cnt <= r_buf_cnt;
        end
      endcase
    end
  end

`ifdef HWPE_STREAM_BURST_READER_STRB_CHECK_EN
  logic r_strb_err;

  assign strb_err_o = r_strb_err;

  // Sticky flag for partial strobes on any accepted beat except the burst's last one.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_strb_err <= 1'b0;
    end else if ((r_state == IDLE) && start_i) begin
      r_strb_err <= 1'b0;
    end else if (w_push && !w_in_final && (in_i.strb != {STRB_WIDTH{1'b1}})) begin
      r_strb_err <= 1'b1;
    end else begin
      r_strb_err <= r_strb_err;
    end
  end
`endif

endmodule

// File: tb/tb_hwpe_stream_burst_reader.sv
// Directed bench for hwpe_stream_burst_reader.
// Inputs change 1 time unit after each rising edge; outputs depend only on registers and are checked there.
module tb_hwpe_stream_burst_reader;
  logic        clk;
  logic        rst;
  logic        clear;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        last;
`ifdef HWPE_STREAM_BURST_READER_STRB_CHECK_EN
  logic        strb_err;
`endif
  int total;
  int bad;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

  hwpe_stream_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .start_i    (start),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .last_o     (last),
`ifdef HWPE_STREAM_BURST_READER_STRB_CHECK_EN
    .strb_err_o (strb_err),
`endif
    .in_i       (in_if),
    .out_o      (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] d;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear = 1'b0;
    start = 1'b0;
    len   = 16'd0;
    in_if.valid  = 1'b0;
    in_if.data   = 32'h0;
    in_if.strb   = 4'h0;
    out_if.ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_done",  64'(done),         64'd0);
    chk("rst_last",  64'(last),         64'd0);
    chk("rst_ovld",  64'(out_if.valid), 64'd0);
    chk("rst_irdy",  64'(in_if.ready),  64'd0);
    rst = 1'b0;

    // len=4, back-to-back beats, no back-pressure
    start = 1'b1;
    len   = 16'd4;
    tick();
    start = 1'b0;
    chk("b4_busy", 64'(busy), 64'd1);
    in_if.valid = 1'b1;
    in_if.strb  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      d = 32'hD000_0000 + 32'(i);
      in_if.data = d;
      chk("b4_irdy", 64'(in_if.ready), 64'd1);
      tick();
      chk("b4_data", 64'(out_if.data),  64'(d));
      chk("b4_ovld", 64'(out_if.valid), 64'd1);
      chk("b4_last", 64'(last),         (i == 3) ? 64'd1 : 64'd0);
      chk("b4_done_early", 64'(done),   64'd0);
    end
    in_if.valid = 1'b0;
    tick();
    chk("b4_done", 64'(done),         64'd1);
    chk("b4_idle", 64'(busy),         64'd0);
    chk("b4_ovld_end", 64'(out_if.valid), 64'd0);
    tick();
    chk("b4_done_pulse", 64'(done), 64'd0);

    // len=3 with 5 cycles of downstream back-pressure
    out_if.ready = 1'b0;
    start = 1'b1;
    len   = 16'd3;
    tick();
    start = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = 32'hE000_0000;
    in_if.strb  = 4'h5;
    chk("bp_irdy0", 64'(in_if.ready), 64'd1);
    tick();
    in_if.data = 32'hE000_0001;
    in_if.strb = 4'hF;
    chk("bp_irdy1", 64'(in_if.ready), 64'd1);
    chk("bp_d0a",   64'(out_if.data), 64'hE000_0000);
    chk("bp_s0",    64'(out_if.strb), 64'h5);
    tick();
    in_if.data = 32'hE000_0002;
    chk("bp_full",  64'(in_if.ready), 64'd0);
    chk("bp_d0b",   64'(out_if.data), 64'hE000_0000);
    tick();
    chk("bp_full2", 64'(in_if.ready), 64'd0);
    chk("bp_d0c",   64'(out_if.data), 64'hE000_0000);
    tick();
    chk("bp_full3", 64'(in_if.ready), 64'd0);
    chk("bp_d0d",   64'(out_if.data), 64'hE000_0000);
    chk("bp_ovld",  64'(out_if.valid), 64'd1);
    out_if.ready = 1'b1;
    chk("bp_rel_irdy", 64'(in_if.ready), 64'd0);
    tick();
    chk("bp_d1",      64'(out_if.data), 64'hE000_0001);
    chk("bp_irdy_rel", 64'(in_if.ready), 64'd1);
    chk("bp_last1",   64'(last),        64'd0);
    tick();
    in_if.valid = 1'b0;
    chk("bp_d2",    64'(out_if.data), 64'hE000_0002);
    chk("bp_last2", 64'(last),        64'd1);
    chk("bp_drain_irdy", 64'(in_if.ready), 64'd0);
    tick();
    chk("bp_done", 64'(done), 64'd1);
    chk("bp_idle", 64'(busy), 64'd0);
    tick();

    // len=0: immediate done, never busy
    start = 1'b1;
    len   = 16'd0;
    tick();
    start = 1'b0;
    chk("z_done", 64'(done),        64'd1);
    chk("z_busy", 64'(busy),        64'd0);
    chk("z_irdy", 64'(in_if.ready), 64'd0);
    tick();
    chk("z_done_pulse", 64'(done), 64'd0);
    chk("z_irdy2", 64'(in_if.ready), 64'd0);

    // len=8, clear after 3 accepted beats, then a normal len=2 burst
    start = 1'b1;
    len   = 16'd8;
    tick();
    start = 1'b0;
    in_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_if.data = 32'hF000_0000 + 32'(i);
      tick();
    end
    in_if.valid = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 64'(busy),         64'd0);
    chk("clr_ovld", 64'(out_if.valid), 64'd0);
    chk("clr_done", 64'(done),         64'd0);
    tick();
    chk("clr_done2", 64'(done), 64'd0);
    start = 1'b1;
    len   = 16'd2;
    tick();
    start = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = 32'hA000_0000;
    tick();
    chk("c2_d0",    64'(out_if.data), 64'hA000_0000);
    chk("c2_last0", 64'(last),        64'd0);
    in_if.data  = 32'hA000_0001;
    tick();
    in_if.valid = 1'b0;
    chk("c2_d1",    64'(out_if.data), 64'hA000_0001);
    chk("c2_last1", 64'(last),        64'd1);
    tick();
    chk("c2_done", 64'(done), 64'd1);
    chk("c2_idle", 64'(busy), 64'd0);
    tick();

    // len=5 with a second start_i (len=9) during RUN: must be ignored
    start = 1'b1;
    len   = 16'd5;
    tick();
    start = 1'b0;
    in_if.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 32'hB000_0000 + 32'(i);
      in_if.data = d;
      if (i == 1) begin
        start = 1'b1;
        len   = 16'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("rs_data", 64'(out_if.data), 64'(d));
      chk("rs_last", 64'(last),        (i == 4) ? 64'd1 : 64'd0);
    end
    in_if.valid = 1'b0;
    chk("rs_drain_irdy", 64'(in_if.ready), 64'd0);
    chk("rs_busy",       64'(busy),        64'd1);
    tick();
    chk("rs_done", 64'(done), 64'd1);
    chk("rs_idle", 64'(busy), 64'd0);
    tick();

`ifdef HWPE_STREAM_BURST_READER_STRB_CHECK_EN
    // Partial strobes: only the non-final beat with strb=0x3 sets the flag
    start = 1'b1;
    len   = 16'd3;
    tick();
    start = 1'b0;
    chk("se_init", 64'(strb_err), 64'd0);
    in_if.valid = 1'b1;
    in_if.data  = 32'hC000_0000;
    in_if.strb  = 4'hF;
    tick();
    chk("se_b1", 64'(strb_err), 64'd0);
    in_if.strb  = 4'h3;
    tick();
    chk("se_b2", 64'(strb_err), 64'd1);
    in_if.strb  = 4'h1;
    tick();
    in_if.valid = 1'b0;
    chk("se_b3", 64'(strb_err), 64'd1);
    tick();
    tick();
    chk("se_hold", 64'(strb_err), 64'd1);
    start = 1'b1;
    len   = 16'd0;
    tick();
    start = 1'b0;
    chk("se_clr", 64'(strb_err), 64'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
